// File: rtl/awgn_pkg.sv
// -----------------------------------------------------------------------------
// awgn_pkg
// Shared constants and types for the AWGN statistics monitor.
//   AWGN_SAMPLE_W : width of one noise sample (two's complement)
//   AWGN_LOG2_N   : default log2 of the measurement window length
//   AWGN_SUM_W    : width of the window sum at the default window length
//   AWGN_SQ_W     : width of the window sum of squares at the default length
//   state_t       : measurement FSM states
// -----------------------------------------------------------------------------
package awgn_pkg;

    localparam int AWGN_SAMPLE_W = 16;
    localparam int AWGN_LOG2_N   = 10;
    localparam int AWGN_SUM_W    = AWGN_SAMPLE_W + AWGN_LOG2_N;
    localparam int AWGN_SQ_W     = 2 * AWGN_SAMPLE_W + AWGN_LOG2_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/awgn_stats_monitor_sq_acc.sv
// -----------------------------------------------------------------------------
// awgn_sq_acc
// Two-stage square-and-accumulate pipe for the statistics monitor.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the accumulator and drop anything in flight
//   in_valid     : sample_in is to be squared and accumulated
//   sample_in    : signed sample
//   sumsq        : running unsigned sum of squares
//   idle         : no sample is still travelling through the pipe
// Stage 1 holds the sample, stage 2 its square, and the accumulator absorbs
// stage 2 one edge later, so a sample reaches sumsq two edges after entry.
// -----------------------------------------------------------------------------
module awgn_sq_acc
    import awgn_pkg::*;
#(
    parameter int SAMPLE_W = AWGN_SAMPLE_W,
    parameter int LOG2_N   = AWGN_LOG2_N
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_W-1:0]     sample_in,
    output logic [2*SAMPLE_W+LOG2_N-1:0]   sumsq,
    output logic                           idle
);

    logic signed [SAMPLE_W-1:0]   stage1;
    logic                         stage1_valid;
    logic [2*SAMPLE_W-1:0]        stage2;
    logic                         stage2_valid;
    logic signed [2*SAMPLE_W-1:0] stage1_ext;
    logic signed [2*SAMPLE_W-1:0] square;

    // Square is at most 2^30 for -32768, so the full-width product's low
    // 2*SAMPLE_W bits are exact and always non-negative.
    assign stage1_ext = $signed({{SAMPLE_W{stage1[SAMPLE_W-1]}}, stage1});
    assign square     = stage1_ext * stage1_ext;
    assign idle       = !stage1_valid && !stage2_valid;

    // Pipeline registers and accumulator.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            stage1       <= '0;
            stage1_valid <= 1'b0;
            stage2       <= '0;
            stage2_valid <= 1'b0;
            sumsq        <= '0;
        end else begin
            stage1_valid <= in_valid;
            if (in_valid) begin
                stage1 <= sample_in;
            end
            stage2_valid <= stage1_valid;
            if (stage1_valid) begin
                stage2 <= $unsigned(square);
            end
            if (stage2_valid) begin
                sumsq <= sumsq + {{LOG2_N{1'b0}}, stage2};
            end
        end
    end

endmodule

// File: rtl/awgn_stats_monitor.sv
// -----------------------------------------------------------------------------
// awgn_stats_monitor
// Measures mean and mean power of a signed noise stream over a window of
// 2^LOG2_N accepted samples, and optionally the peak magnitude.
//   clock, reset  : system clock, synchronous active-high reset
//   start         : pulse to arm a new window (ignored while measuring)
//   sample_in     : signed noise sample, sample_valid qualifies it
//   busy          : a window is being measured or drained
//   done          : results valid, held until the next accepted start
//   sum_out       : signed window sum
//   sumsq_out     : unsigned window sum of squares
//   mean_out      : floor(sum / N)
//   power_out     : sumsq / N
//   max_abs_out   : peak |sample| (0 unless the peak feature is built)
// Build option: define AWGN_STATS_PEAK_EN to include peak-magnitude tracking.
// -----------------------------------------------------------------------------
module awgn_stats_monitor
    import awgn_pkg::*;
#(
    parameter int SAMPLE_W = AWGN_SAMPLE_W,
    parameter int LOG2_N   = AWGN_LOG2_N
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic signed [SAMPLE_W-1:0]          sample_in,
    input  logic                                sample_valid,
    output logic                                busy,
    output logic                                done,
    output logic signed [SAMPLE_W+LOG2_N-1:0]   sum_out,
    output logic [2*SAMPLE_W+LOG2_N-1:0]        sumsq_out,
    output logic signed [SAMPLE_W-1:0]          mean_out,
    output logic [2*SAMPLE_W-1:0]               power_out,
    output logic [SAMPLE_W-1:0]                 max_abs_out
);

    localparam int                SUM_W    = SAMPLE_W + LOG2_N;
    localparam int                SQ_W     = 2 * SAMPLE_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    state_t                  state;
    state_t                  next_state;
    logic [LOG2_N-1:0]       sample_cnt;
    logic signed [SUM_W-1:0] sum_acc;
    logic [SQ_W-1:0]         sumsq_acc;
    logic                    pipe_idle;
    logic                    arm;
    logic                    accept;
    logic                    capture;

    assign arm     = start && (state == IDLE || state == DONE);
    assign accept  = sample_valid && (state == ACCUM);
    // The squaring pipe drains two edges after the last accept; the results
    // are captured on the following edge, once sumsq has absorbed it.
    assign capture = (state == FLUSH) && pipe_idle;

    assign busy = (state == ACCUM) || (state == FLUSH);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a window closes when the counter wraps to zero.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = ACCUM;
            ACCUM:      if (accept && sample_cnt == LAST_IDX) next_state = FLUSH;
            FLUSH:      if (pipe_idle) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Sample counter, running sum and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_cnt <= '0;
            sum_acc    <= '0;
            sum_out    <= '0;
            sumsq_out  <= '0;
            mean_out   <= '0;
            power_out  <= '0;
        end else begin
            if (arm) begin
                sample_cnt <= '0;
                sum_acc    <= '0;
            end else if (accept) begin
                sample_cnt <= sample_cnt + 1'b1;
                sum_acc    <= sum_acc + {{LOG2_N{sample_in[SAMPLE_W-1]}}, sample_in};
            end
            // Dropping the low LOG2_N bits of a two's complement value is a
            // floor division by N, which is the intended mean rounding.
            if (capture) begin
                sum_out   <= sum_acc;
                sumsq_out <= sumsq_acc;
                mean_out  <= sum_acc[SUM_W-1:LOG2_N];
                power_out <= sumsq_acc[SQ_W-1:LOG2_N];
            end
        end
    end

    awgn_sq_acc #(
        .SAMPLE_W (SAMPLE_W),
        .LOG2_N   (LOG2_N)
    ) u_sq_acc (
        .clock     (clock),
        .reset     (reset),
        .clear     (arm),
        .in_valid  (accept),
        .sample_in (sample_in),
        .sumsq     (sumsq_acc),
        .idle      (pipe_idle)
    );

`ifdef AWGN_STATS_PEAK_EN
    logic [SAMPLE_W-1:0] sample_abs;
    logic [SAMPLE_W-1:0] peak;

    // Negating the most negative sample wraps to 1 << (SAMPLE_W-1), which is
    // exactly its magnitude when read as unsigned.
    assign sample_abs = sample_in[SAMPLE_W-1] ? $unsigned(-sample_in) : $unsigned(sample_in);

    // Peak tracking at the accept edge, published with the other results.
    always_ff @(posedge clock) begin
        if (reset) begin
            peak        <= '0;
            max_abs_out <= '0;
        end else begin
            if (arm) begin
                peak <= '0;
            end else if (accept && sample_abs > peak) begin
                peak <= sample_abs;
            end
            if (capture) begin
                max_abs_out <= peak;
            end
        end
    end
`else
    assign max_abs_out = '0;
`endif

endmodule
